// File: rtl/notch_power_monitor_pkg.sv
// Shared constants, types and per-sample helpers for the notch power monitor.
package notch_mon_pkg;

  localparam int NBITS     = 12;
  localparam int NSAMP     = 4;
  localparam int WIN_BITS  = 16;
  localparam int SQ_BITS   = 2*NBITS-1;
  localparam int SUM_BITS  = 2*NBITS+1;
  localparam int ACC_BITS  = 2*NBITS+1+WIN_BITS;
  localparam int CLIP_BITS = WIN_BITS+3;
  localparam int POP_BITS  = 3;

  typedef logic [NBITS-1:0]       sample_t;
  typedef logic [NBITS*NSAMP-1:0] word_t;

  // One reduced word leaving the E2 stage, enable carried alongside.
  typedef struct packed {
    logic                en;
    logic [SUM_BITS-1:0] sum;
    sample_t             max;
    logic [POP_BITS-1:0] pop;
  } e2_t;

  // Sample k of a bus word (two's complement bits, unchanged).
  function automatic sample_t sample_at(input word_t w, input int unsigned k);
    sample_at = w[NBITS*k +: NBITS];
  endfunction

  // Magnitude as unsigned; the most negative value maps to 2^(NBITS-1) exactly.
  function automatic sample_t abs_val(input sample_t s);
    if (s[NBITS-1]) begin
      abs_val = ~s + {{(NBITS-1){1'b0}}, 1'b1};
    end else begin
      abs_val = s;
    end
  endfunction

  // Sample sits on either full-scale rail.
  function automatic logic is_clip(input sample_t s);
    is_clip = (s == {1'b0, {(NBITS-1){1'b1}}}) || (s == {1'b1, {(NBITS-1){1'b0}}});
  endfunction

endpackage

// File: rtl/notch_power_monitor_if.sv
// Sample bus in, result set out, between the notch and the power monitor.
interface notch_power_monitor_if;
  import notch_mon_pkg::*;

  word_t                dat_i;
  logic                 enable_i;
  logic [WIN_BITS-1:0]  window_i;
  logic [ACC_BITS-1:0]  power_o;
  sample_t              peak_o;
  logic [CLIP_BITS-1:0] clip_count_o;
  logic                 power_valid_o;

  modport master (
    output dat_i, enable_i, window_i,
    input  power_o, peak_o, clip_count_o, power_valid_o
  );

  modport slave (
    input  dat_i, enable_i, window_i,
    output power_o, peak_o, clip_count_o, power_valid_o
  );

endinterface

// File: rtl/notch_power_monitor_sq_sum4.sv
// E1/E2 pipeline: per-sample square, magnitude and clip flag, then the
// 4-way sum, max and popcount. Enable rides along unchanged.
module sq_sum4
  import notch_mon_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  word_t dat_i,
  input  logic  en_i,
  output e2_t   e2_o
);

  logic [SQ_BITS-1:0]  sq_s     [NSAMP];
  sample_t             abs_s    [NSAMP];
  logic [NSAMP-1:0]    clip_s;
  logic [SQ_BITS-1:0]  sq_e1_r  [NSAMP];
  sample_t             abs_e1_r [NSAMP];
  logic [NSAMP-1:0]    clip_e1_r;
  logic                en_e1_r;
  logic [SUM_BITS-1:0] sum_s;
  sample_t             max_s;
  logic [POP_BITS-1:0] pop_s;
  e2_t                 e2_r;

  // E1 combinational: magnitude, square from magnitude (never exceeds 2^22), clip flag.
  always_comb begin
    for (int k = 0; k < NSAMP; k++) begin
      abs_s[k]  = abs_val(sample_at(dat_i, k));
      sq_s[k]   = {{(SQ_BITS-NBITS){1'b0}}, abs_s[k]} * {{(SQ_BITS-NBITS){1'b0}}, abs_s[k]};
      clip_s[k] = is_clip(sample_at(dat_i, k));
    end
  end

  // E1 register stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NSAMP; k++) begin
        sq_e1_r[k]  <= {SQ_BITS{1'b0}};
        abs_e1_r[k] <= {NBITS{1'b0}};
      end
      clip_e1_r <= {NSAMP{1'b0}};
      en_e1_r   <= 1'b0;
    end else begin
      for (int k = 0; k < NSAMP; k++) begin
        sq_e1_r[k]  <= sq_s[k];
        abs_e1_r[k] <= abs_s[k];
      end
      clip_e1_r <= clip_s;
      en_e1_r   <= en_i;
    end
  end

  // E2 combinational: reduce the four lanes to one sum, one max, one clip count.
  always_comb begin
    sum_s = {SUM_BITS{1'b0}};
    max_s = {NBITS{1'b0}};
    pop_s = {POP_BITS{1'b0}};
    for (int k = 0; k < NSAMP; k++) begin
      sum_s = sum_s + {{(SUM_BITS-SQ_BITS){1'b0}}, sq_e1_r[k]};
      if (abs_e1_r[k] > max_s) begin
        max_s = abs_e1_r[k];
      end else begin
        max_s = max_s;
      end
      pop_s = pop_s + {{(POP_BITS-1){1'b0}}, clip_e1_r[k]};
    end
  end

  // E2 register stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e2_r <= {1'b0, {SUM_BITS{1'b0}}, {NBITS{1'b0}}, {POP_BITS{1'b0}}};
    end else begin
      e2_r <= '{en: en_e1_r, sum: sum_s, max: max_s, pop: pop_s};
    end
  end

  assign e2_o = e2_r;

endmodule

// File: rtl/notch_power_monitor.sv
// Windowed band-power monitor: E0 capture, E1/E2 reduction, E3 window
// accumulation with one result set per window of window_q+1 clocks.
module notch_power_monitor
  import notch_mon_pkg::*;
(
  input logic                  clk_i,
  input logic                  rst_ni,
  notch_power_monitor_if.slave bus
);

  word_t                dat_e0_r;
  logic                 en_e0_r;
  e2_t                  e2_s;
  logic [WIN_BITS-1:0]  cnt_r, cnt_nxt_s, win_q_r, win_q_nxt_s, win_eff_s;
  logic [ACC_BITS-1:0]  acc_r, acc_nxt_s, acc_sum_s, power_r, power_nxt_s;
  sample_t              peak_acc_r, peak_acc_nxt_s, peak_cand_s, peak_r, peak_nxt_s;
  logic [CLIP_BITS-1:0] clip_acc_r, clip_acc_nxt_s, clip_sum_s, clip_r, clip_nxt_s;
  logic                 valid_r, valid_nxt_s;

  // E0: register the incoming word and its enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dat_e0_r <= {(NBITS*NSAMP){1'b0}};
      en_e0_r  <= 1'b0;
    end else begin
      dat_e0_r <= bus.dat_i;
      en_e0_r  <= bus.enable_i;
    end
  end

  sq_sum4 u_sq_sum4 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .dat_i  (dat_e0_r),
    .en_i   (en_e0_r),
    .e2_o   (e2_s)
  );

  // Running totals including the current E2 word; the first word of a window
  // sees the live window_i because that is the value being captured.
  always_comb begin
    if (cnt_r == {WIN_BITS{1'b0}}) begin
      win_eff_s = bus.window_i;
    end else begin
      win_eff_s = win_q_r;
    end
    acc_sum_s  = acc_r + {{(ACC_BITS-SUM_BITS){1'b0}}, e2_s.sum};
    clip_sum_s = clip_acc_r + {{(CLIP_BITS-POP_BITS){1'b0}}, e2_s.pop};
    if (e2_s.max > peak_acc_r) begin
      peak_cand_s = e2_s.max;
    end else begin
      peak_cand_s = peak_acc_r;
    end
  end

  // E3 next state: accumulate, publish at the terminal word, discard on enable low.
  always_comb begin
    cnt_nxt_s      = cnt_r;
    win_q_nxt_s    = win_q_r;
    acc_nxt_s      = acc_r;
    peak_acc_nxt_s = peak_acc_r;
    clip_acc_nxt_s = clip_acc_r;
    power_nxt_s    = power_r;
    peak_nxt_s     = peak_r;
    clip_nxt_s     = clip_r;
    valid_nxt_s    = 1'b0;
    if (e2_s.en) begin
      if (cnt_r == {WIN_BITS{1'b0}}) begin
        win_q_nxt_s = bus.window_i;
      end else begin
        win_q_nxt_s = win_q_r;
      end
      if (cnt_r == win_eff_s) begin
        power_nxt_s    = acc_sum_s;
        peak_nxt_s     = peak_cand_s;
        clip_nxt_s     = clip_sum_s;
        valid_nxt_s    = 1'b1;
        cnt_nxt_s      = {WIN_BITS{1'b0}};
        acc_nxt_s      = {ACC_BITS{1'b0}};
        peak_acc_nxt_s = {NBITS{1'b0}};
        clip_acc_nxt_s = {CLIP_BITS{1'b0}};
      end else begin
        cnt_nxt_s      = cnt_r + {{(WIN_BITS-1){1'b0}}, 1'b1};
        acc_nxt_s      = acc_sum_s;
        peak_acc_nxt_s = peak_cand_s;
        clip_acc_nxt_s = clip_sum_s;
      end
    end else begin
      cnt_nxt_s      = {WIN_BITS{1'b0}};
      acc_nxt_s      = {ACC_BITS{1'b0}};
      peak_acc_nxt_s = {NBITS{1'b0}};
      clip_acc_nxt_s = {CLIP_BITS{1'b0}};
    end
  end

  // E3 registers: window state and result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r      <= {WIN_BITS{1'b0}};
      win_q_r    <= {WIN_BITS{1'b0}};
      acc_r      <= {ACC_BITS{1'b0}};
      peak_acc_r <= {NBITS{1'b0}};
      clip_acc_r <= {CLIP_BITS{1'b0}};
      power_r    <= {ACC_BITS{1'b0}};
      peak_r     <= {NBITS{1'b0}};
      clip_r     <= {CLIP_BITS{1'b0}};
      valid_r    <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      win_q_r    <= win_q_nxt_s;
      acc_r      <= acc_nxt_s;
      peak_acc_r <= peak_acc_nxt_s;
      clip_acc_r <= clip_acc_nxt_s;
      power_r    <= power_nxt_s;
      peak_r     <= peak_nxt_s;
      clip_r     <= clip_nxt_s;
      valid_r    <= valid_nxt_s;
    end
  end

  assign bus.power_o       = power_r;
  assign bus.peak_o        = peak_r;
  assign bus.clip_count_o  = clip_r;
  assign bus.power_valid_o = valid_r;

endmodule

// File: tb/tb_notch_power_monitor.sv
// Bench for notch_power_monitor: directed vector table, hand-written corner
// sequences and a randomized run, all against a window-level reference model.
module tb_notch_power_monitor;
  import notch_mon_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  notch_power_monitor_if bus ();
  notch_power_monitor dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: words enter at the sampling edge and are judged three
  // edges later against whole-window sums.
  logic   h_en  [4];
  word_t  h_dat [4];
  int     m_cnt, m_win, m_peak, m_clip;
  longint m_acc;
  longint e_power;
  int     e_peak, e_clip;
  logic   e_valid;

  typedef struct {
    word_t       dat;
    logic [15:0] win;
    longint      power;
    int          peak;
    int          clip;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      h_en[i]  = 1'b0;
      h_dat[i] = '0;
    end
    m_cnt = 0; m_win = 0; m_acc = 0; m_peak = 0; m_clip = 0;
    e_power = 0; e_peak = 0; e_clip = 0; e_valid = 1'b0;
  endfunction

  function automatic void model_edge();
    logic signed [11:0] sv;
    int s, a;
    for (int i = 3; i > 0; i--) begin
      h_en[i]  = h_en[i-1];
      h_dat[i] = h_dat[i-1];
    end
    h_en[0]  = bus.enable_i;
    h_dat[0] = bus.dat_i;
    e_valid  = 1'b0;
    if (h_en[3]) begin
      if (m_cnt == 0) m_win = int'(bus.window_i);
      for (int k = 0; k < 4; k++) begin
        sv = h_dat[3][12*k +: 12];
        s  = sv;
        a  = (s < 0) ? -s : s;
        m_acc += longint'(s) * longint'(s);
        if (a > m_peak) m_peak = a;
        if (s == 2047 || s == -2048) m_clip++;
      end
      if (m_cnt == m_win) begin
        e_power = m_acc; e_peak = m_peak; e_clip = m_clip; e_valid = 1'b1;
        m_cnt = 0; m_acc = 0; m_peak = 0; m_clip = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0; m_acc = 0; m_peak = 0; m_clip = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
    chk("power", longint'(bus.power_o), e_power);
    chk("peak", longint'(bus.peak_o), longint'(e_peak));
    chk("clip", longint'(bus.clip_count_o), longint'(e_clip));
    chk("valid", longint'(bus.power_valid_o), longint'(e_valid));
  endtask

  // Tick until a valid pulse or the budget runs out; n is ticks consumed.
  task automatic wait_valid(input int lim, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.power_valid_o && n < lim);
    if (!bus.power_valid_o) $display("FAIL wait_valid: no pulse within %0d clocks", lim);
  endtask

  task automatic idle(input int n);
    bus.enable_i = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int n, pulses;
    logic [31:0] rr;
    word_t w;

    vecs[0] = '{dat: {4{12'd100}}, win: 16'd3, power: 64'd160000, peak: 100, clip: 0};
    vecs[1] = '{dat: {4{12'h800}}, win: 16'd0, power: 64'd16777216, peak: 2048, clip: 4};
    vecs[2] = '{dat: {12'd5, 12'd0, 12'hFFF, 12'h7FF}, win: 16'd1, power: 64'd8380470, peak: 2047, clip: 2};
    vecs[3] = '{dat: {4{12'h800}}, win: 16'hFFFF, power: 64'd1099511627776, peak: 2048, clip: 262144};

    // Reset state.
    rst_ni = 1'b0;
    bus.dat_i = '0; bus.enable_i = 1'b0; bus.window_i = '0;
    model_clear();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_power", longint'(bus.power_o), 64'd0);
    chk("rst_peak", longint'(bus.peak_o), 64'd0);
    chk("rst_clip", longint'(bus.clip_count_o), 64'd0);
    chk("rst_valid", longint'(bus.power_valid_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(3);

    // Directed vector table.
    for (int v = 0; v < 4; v++) begin
      bus.dat_i = vecs[v].dat;
      bus.window_i = vecs[v].win;
      bus.enable_i = 1'b1;
      wait_valid(int'(vecs[v].win) + 12, n);
      chk("tbl_latency", n, 64'd4 + longint'(vecs[v].win));
      chk("tbl_power", longint'(bus.power_o), vecs[v].power);
      chk("tbl_peak", longint'(bus.peak_o), longint'(vecs[v].peak));
      chk("tbl_clip", longint'(bus.clip_count_o), longint'(vecs[v].clip));
      if (vecs[v].win < 16'd16) begin
        wait_valid(int'(vecs[v].win) + 4, n);
        chk("tbl_period", n, 64'd1 + longint'(vecs[v].win));
        chk("tbl_power2", longint'(bus.power_o), vecs[v].power);
      end
      idle(6);
    end

    // Enable dropped after two words of a window_i=7 window, re-raised 5 clocks later.
    bus.dat_i = {4{12'd300}};
    bus.window_i = 16'd7;
    bus.enable_i = 1'b1;
    pulses = 0;
    repeat (2) begin tick(); pulses += int'(bus.power_valid_o); end
    bus.enable_i = 1'b0;
    repeat (5) begin tick(); pulses += int'(bus.power_valid_o); end
    chk("partial_pulse", pulses, 64'd0);
    bus.enable_i = 1'b1;
    wait_valid(20, n);
    chk("reen_latency", n, 64'd11);
    chk("reen_power", longint'(bus.power_o), 64'd2880000);
    idle(6);

    // window_i changed 3 -> 1 after the window has started.
    bus.dat_i = {4{12'd10}};
    bus.window_i = 16'd3;
    bus.enable_i = 1'b1;
    repeat (5) tick();
    bus.window_i = 16'd1;
    wait_valid(10, n);
    chk("wchg_first", n + 5, 64'd7);
    chk("wchg_power1", longint'(bus.power_o), 64'd1600);
    for (int r = 0; r < 2; r++) begin
      wait_valid(6, n);
      chk("wchg_period", n, 64'd2);
      chk("wchg_power2", longint'(bus.power_o), 64'd800);
    end
    idle(6);

    // Reset mid-window: outputs clear before the next edge; next result needs a full window.
    bus.window_i = 16'd3;
    bus.enable_i = 1'b1;
    wait_valid(12, n);
    repeat (2) tick();
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_power", longint'(bus.power_o), 64'd0);
    chk("arst_peak", longint'(bus.peak_o), 64'd0);
    chk("arst_clip", longint'(bus.clip_count_o), 64'd0);
    chk("arst_valid", longint'(bus.power_valid_o), 64'd0);
    model_clear();
    #1 rst_ni = 1'b1;
    wait_valid(12, n);
    chk("post_rst_latency", n, 64'd7);
    chk("post_rst_power", longint'(bus.power_o), 64'd1600);
    idle(6);

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++) begin
        rr = $urandom();
        case (rr[31:29])
          3'd0:    w[12*k +: 12] = 12'h7FF;
          3'd1:    w[12*k +: 12] = 12'h800;
          default: w[12*k +: 12] = rr[11:0];
        endcase
      end
      bus.dat_i = w;
      bus.enable_i = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 49) == 0) bus.window_i = 16'($urandom_range(0, 5));
      tick();
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
